product_bcd_converter: RTL and testbench

Sequential double-dabble converter that sits directly downstream of the multiplier. It takes the 2*DW-bit two's-complement product and produces a sign flag plus DIGITS packed BCD digits for the seven-segment display driver. A conversion is started by a one-cycle load, typically the multiplier's ready. Each conversion takes a fixed IW+1 cycles and is signalled by a one-cycle done pulse.

---
 rtl/product_bcd_converter.sv | 123 ++++++++++++
 tb/tb_product_bcd_converter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_converter.sv
// product_bcd_converter: sequential double-dabble binary-to-BCD converter for the
// multiplier product. A one-cycle load in IDLE starts a fixed IW+1 cycle conversion
// that ends with a one-cycle done pulse, at which point bcd and sign update together.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-low reset
//   load    start conversion of bin_in (sampled only in IDLE)
//   bin_in  product value to convert (IW bits, two's complement when SIGNED=1)
//   busy    high while a conversion is in progress
//   done    one-cycle pulse: bcd/sign updated this cycle
//   sign    1 = converted value was negative
//   bcd     packed BCD result, digit 0 in bits [3:0]
module product_bcd_converter #(
    parameter int unsigned DW     = 9,
    parameter int unsigned IW     = 2 * DW,
    parameter int unsigned DIGITS = 6,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [IW-1:0]         bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned CW = (IW > 1) ? $clog2(IW) : 1;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam longint unsigned MaxMag = SIGNED ? (64'd1 << (IW - 1))
                                                : ((64'd1 << IW) - 64'd1);

    if (pow10(DIGITS) <= MaxMag) begin : g_width_check
        $error("product_bcd_converter: DIGITS too small for IW");
    end

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state;
    logic [IW-1:0]   bin_reg;
    logic [SW-1:0]   scratch;
    logic [CW-1:0]   cnt;
    logic            sign_r;

    logic [IW-1:0]   mag;
    logic            neg;
    logic [SW-1:0]   scratch_adj;

    // Magnitude of the input; the most-negative value maps onto 2^(IW-1) unchanged.
    always_comb begin
        neg = SIGNED && bin_in[IW-1];
        mag = neg ? (~bin_in + IW'(1)) : bin_in;
    end

    // Add-3 correction on every digit >= 5 ahead of the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            bin_reg <= '0;
            scratch <= '0;
            cnt     <= '0;
            sign_r  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sign    <= 1'b0;
            bcd     <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (load) begin
                        bin_reg <= mag;
                        sign_r  <= neg;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= StShift;
                    end
                end
                StShift: begin
                    scratch <= {scratch_adj[SW-2:0], bin_reg[IW-1]};
                    bin_reg <= {bin_reg[IW-2:0], 1'b0};
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(IW - 1)) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    bcd   <= scratch;
                    sign  <= sign_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: a signed default instance and an
// unsigned instance sharing clock and reset.
module tb_product_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [17:0] bin_in;
    logic        busy, done, sign;
    logic [23:0] bcd;

    logic        load_u;
    logic [17:0] bin_u;
    logic        busy_u, done_u, sign_u;
    logic [23:0] bcd_u;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    product_bcd_converter dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .sign   (sign),
        .bcd    (bcd)
    );

    product_bcd_converter #(.SIGNED(1'b0)) dut_u (
        .clk    (clk),
        .rst    (rst),
        .load   (load_u),
        .bin_in (bin_u),
        .busy   (busy_u),
        .done   (done_u),
        .sign   (sign_u),
        .bcd    (bcd_u)
    );

    // Stimulus/observation only: loads v, then watches n edges recording the first
    // done edge, the done pulse count and the first edge at which busy is low.
    task automatic convert(input logic [17:0] v, input int n, output int done_edge,
                           output int done_cnt, output int busy_low);
        bin_in = v;
        load   = 1'b1;
        @(posedge clk); #1;
        load      = 1'b0;
        bin_in    = 18'h2AAAA;
        done_edge = -1;
        done_cnt  = 0;
        busy_low  = busy ? -1 : 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
            end
            if (!busy && busy_low < 0) busy_low = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; bin_in = '0; load_u = 1'b0; bin_u = '0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, sign, bcd} !== 27'd0) begin
            failures++;
            $display("FAIL reset_signed: got %h expected 0", {busy, done, sign, bcd});
        end
        checks++;
        if ({busy_u, done_u, sign_u, bcd_u} !== 27'd0) begin
            failures++;
            $display("FAIL reset_unsigned: got %h expected 0", {busy_u, done_u, sign_u, bcd_u});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        int de, dc, bl;
        convert(18'd10795, 25, de, dc, bl);
        checks++;
        if (de !== 19) begin
            failures++; $display("FAIL latency_done_edge: got %0d expected 19", de);
        end
        checks++;
        if (dc !== 1) begin
            failures++; $display("FAIL latency_done_count: got %0d expected 1", dc);
        end
        checks++;
        if (bl !== 19) begin
            failures++; $display("FAIL latency_busy_low_edge: got %0d expected 19", bl);
        end
        checks++;
        if (bcd !== 24'h010795 || sign !== 1'b0) begin
            failures++;
            $display("FAIL latency_result: got bcd=%h sign=%b expected 010795/0", bcd, sign);
        end
    endtask

    task automatic test_back_to_back();
        int de, dc, bl;
        convert(18'd7225, 19, de, dc, bl);
        checks++;
        if (de !== 19 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_done: got edge=%0d done=%b expected 19/1", de, done);
        end
        checks++;
        if (bcd !== 24'h007225 || sign !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_result: got bcd=%h sign=%b expected 007225/0", bcd, sign);
        end
        // Load issued during the done cycle.
        convert(18'h3D5D5, 25, de, dc, bl);
        checks++;
        if (de !== 19 || dc !== 1) begin
            failures++;
            $display("FAIL b2b_second_done: got edge=%0d cnt=%0d expected 19/1", de, dc);
        end
        checks++;
        if (bcd !== 24'h010795 || sign !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_result: got bcd=%h sign=%b expected 010795/1", bcd, sign);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        bin_in = 18'd7225;
        load   = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sign !== 1'b0 || bcd !== 24'h0) begin
            failures++;
            $display("FAIL midreset_outputs: got busy=%b done=%b sign=%b bcd=%h expected 0",
                     busy, done, sign, bcd);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        dc  = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy) dc++;
        end
        checks++;
        if (dc !== 0) begin
            failures++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", dc);
        end
    endtask

    task automatic test_nines();
        int de, dc, bl;
        convert(18'd999, 22, de, dc, bl);
        checks++;
        if (de !== 19 || bcd !== 24'h000999 || sign !== 1'b0) begin
            failures++;
            $display("FAIL nines: got edge=%0d bcd=%h sign=%b expected 19/000999/0",
                     de, bcd, sign);
        end
    endtask

    task automatic test_boundaries();
        int de, dc, bl;
        convert(18'h20000, 22, de, dc, bl);
        checks++;
        if (de !== 19 || bcd !== 24'h131072 || sign !== 1'b1) begin
            failures++;
            $display("FAIL most_negative: got edge=%0d bcd=%h sign=%b expected 19/131072/1",
                     de, bcd, sign);
        end
        convert(18'd0, 22, de, dc, bl);
        checks++;
        if (de !== 19 || bcd !== 24'h000000 || sign !== 1'b0) begin
            failures++;
            $display("FAIL zero: got edge=%0d bcd=%h sign=%b expected 19/000000/0",
                     de, bcd, sign);
        end
    endtask

    task automatic test_unsigned();
        int de;
        bin_u  = 18'h3FFFF;
        load_u = 1'b1;
        @(posedge clk); #1;
        load_u = 1'b0;
        bin_u  = 18'h0;
        de     = -1;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            if (done_u && de < 0) de = k;
        end
        checks++;
        if (de !== 19 || bcd_u !== 24'h262143 || sign_u !== 1'b0) begin
            failures++;
            $display("FAIL unsigned_max: got edge=%0d bcd=%h sign=%b expected 19/262143/0",
                     de, bcd_u, sign_u);
        end
    endtask

    task automatic test_ignored_load();
        int de, dc;
        bin_in = 18'd10795;
        load   = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        de   = -1;
        dc   = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dc++;
                if (de < 0) de = k;
            end
            if (k == 4) begin
                bin_in = 18'd1;
                load   = 1'b1;
            end else if (k == 5) begin
                load = 1'b0;
            end
        end
        checks++;
        if (de !== 19 || dc !== 1) begin
            failures++;
            $display("FAIL ignored_load_done: got edge=%0d cnt=%0d expected 19/1", de, dc);
        end
        checks++;
        if (bcd !== 24'h010795 || sign !== 1'b0) begin
            failures++;
            $display("FAIL ignored_load_result: got bcd=%h sign=%b expected 010795/0", bcd, sign);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        test_nines();
        test_boundaries();
        test_unsigned();
        test_ignored_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
